// File: rtl/ising_run_ctrl.sv
// Multi-run sequencer for the Ising core: reset, anneal, snapshot the phase vector into a result buffer.
// Optional early-stop on a stable phase vector is enabled with `define ISING_EARLY_STOP_EN.
module ising_run_ctrl #(
    parameter int N          = 3,
    parameter int DEPTH      = 16,
    parameter int RST_CYCLES = 4,
    parameter int CNT_W      = 32
`ifdef ISING_EARLY_STOP_EN
    ,
    parameter int STABLE_CYCLES = 64
`endif
) (
    input  logic                     clk,
    input  logic                     ising_rst,
    input  logic                     start,
    input  logic                     abort,
    input  logic [15:0]              num_runs,
    input  logic [CNT_W-1:0]         run_cycles,
    input  logic [N-1:0]             phase_in,
    output logic                     core_rstn,
    output logic                     busy,
    output logic                     done,
    output logic                     overflow,
    output logic [15:0]              run_count,
`ifdef ISING_EARLY_STOP_EN
    output logic [15:0]              early_stops,
`endif
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [N-1:0]             rd_data
);

    localparam int AW = $clog2(DEPTH);
    localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RSTQ,
        S_RUN,
        S_CAPT,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [15:0]      num_runs_q, num_runs_d;
    logic [CNT_W-1:0] run_cycles_q, run_cycles_d;
    logic [RW-1:0]    rst_cnt_q, rst_cnt_d;
    logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
    logic [15:0]      run_count_q, run_count_d;
    logic             overflow_q, overflow_d;
    logic             core_rstn_q, core_rstn_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [N-1:0]     rd_data_q;
    logic             buf_we;

    logic [N-1:0]     mem [DEPTH];

`ifdef ISING_EARLY_STOP_EN
    localparam int SW = $clog2(STABLE_CYCLES + 1);
    logic [SW-1:0]    stable_q, stable_d;
    logic [N-1:0]     phase_prev_q;
    logic [15:0]      early_stops_q, early_stops_d;
`endif

    always_comb begin
        state_d      = state_q;
        num_runs_d   = num_runs_q;
        run_cycles_d = run_cycles_q;
        rst_cnt_d    = rst_cnt_q;
        run_cnt_d    = run_cnt_q;
        run_count_d  = run_count_q;
        overflow_d   = overflow_q;
        buf_we       = 1'b0;
`ifdef ISING_EARLY_STOP_EN
        stable_d      = stable_q;
        early_stops_d = early_stops_q;
`endif
        // abort freezes everything except the state, so an abort during CAPT loses that capture
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        num_runs_d   = num_runs;
                        run_cycles_d = (run_cycles == '0) ? CNT_W'(1) : run_cycles;
                        run_count_d  = 16'd0;
                        overflow_d   = 1'b0;
                        rst_cnt_d    = '0;
`ifdef ISING_EARLY_STOP_EN
                        early_stops_d = 16'd0;
`endif
                        state_d = (num_runs == 16'd0) ? S_DONE : S_RSTQ;
                    end
                end
                S_RSTQ: begin
                    if (rst_cnt_q == RW'(RST_CYCLES - 1)) begin
                        state_d   = S_RUN;
                        run_cnt_d = CNT_W'(1);
`ifdef ISING_EARLY_STOP_EN
                        stable_d  = '0;
`endif
                    end else begin
                        rst_cnt_d = rst_cnt_q + RW'(1);
                    end
                end
                S_RUN: begin
`ifdef ISING_EARLY_STOP_EN
                    // the first RUN cycle has no in-run predecessor to compare against
                    if (run_cnt_q == CNT_W'(1) || phase_in != phase_prev_q)
                        stable_d = '0;
                    else
                        stable_d = stable_q + SW'(1);
`endif
                    if (run_cnt_q >= run_cycles_q) begin
                        state_d = S_CAPT;
`ifdef ISING_EARLY_STOP_EN
                    end else if (stable_d == SW'(STABLE_CYCLES)) begin
                        state_d = S_CAPT;
                        if (early_stops_q != 16'hFFFF)
                            early_stops_d = early_stops_q + 16'd1;
`endif
                    end else begin
                        run_cnt_d = run_cnt_q + CNT_W'(1);
                    end
                end
                S_CAPT: begin
                    buf_we = 1'b1;
                    if (run_count_q >= 16'(DEPTH))
                        overflow_d = 1'b1;
                    if (run_count_q != 16'hFFFF)
                        run_count_d = run_count_q + 16'd1;
                    rst_cnt_d = '0;
                    state_d   = (run_count_d == num_runs_q) ? S_DONE : S_RSTQ;
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        core_rstn_d = (state_d == S_RUN) || (state_d == S_CAPT);
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge ising_rst) begin
        if (ising_rst) begin
            state_q      <= S_IDLE;
            num_runs_q   <= 16'd0;
            run_cycles_q <= '0;
            rst_cnt_q    <= '0;
            run_cnt_q    <= '0;
            run_count_q  <= 16'd0;
            overflow_q   <= 1'b0;
            core_rstn_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            rd_data_q    <= '0;
`ifdef ISING_EARLY_STOP_EN
            stable_q      <= '0;
            phase_prev_q  <= '0;
            early_stops_q <= 16'd0;
`endif
        end else begin
            state_q      <= state_d;
            num_runs_q   <= num_runs_d;
            run_cycles_q <= run_cycles_d;
            rst_cnt_q    <= rst_cnt_d;
            run_cnt_q    <= run_cnt_d;
            run_count_q  <= run_count_d;
            overflow_q   <= overflow_d;
            core_rstn_q  <= core_rstn_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            rd_data_q    <= mem[rd_addr];
`ifdef ISING_EARLY_STOP_EN
            stable_q      <= stable_d;
            phase_prev_q  <= phase_in;
            early_stops_q <= early_stops_d;
`endif
        end
    end

    // result buffer is deliberately left out of reset
    always_ff @(posedge clk) begin
        if (buf_we)
            mem[run_count_q[AW-1:0]] <= phase_in;
    end

    assign core_rstn = core_rstn_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign overflow  = overflow_q;
    assign run_count = run_count_q;
    assign rd_data   = rd_data_q;
`ifdef ISING_EARLY_STOP_EN
    assign early_stops = early_stops_q;
`endif

endmodule

// File: tb/tb_ising_run_ctrl.sv
// Randomized self-checking bench for ising_run_ctrl against a per-cycle schedule model.
// Early-stop checks are compiled in only when ISING_EARLY_STOP_EN is defined.
module tb_ising_run_ctrl;

    localparam int N     = 3;
    localparam int DEPTH = 16;
    localparam int RSTC  = 4;
    localparam int CNT_W = 32;
    localparam int AW    = 4;

    logic             clk = 1'b0;
    logic             ising_rst;
    logic             start;
    logic             abort;
    logic [15:0]      num_runs;
    logic [CNT_W-1:0] run_cycles;
    logic [N-1:0]     phase_in;
    logic             core_rstn;
    logic             busy;
    logic             done;
    logic             overflow;
    logic [15:0]      run_count;
    logic [AW-1:0]    rd_addr;
    logic [N-1:0]     rd_data;
`ifdef ISING_EARLY_STOP_EN
    logic [15:0]      early_stops;
`endif

    int errors = 0;
    int checks = 0;

    logic [N-1:0] model_buf   [DEPTH];
    bit           model_valid [DEPTH];

    always #5 clk = ~clk;

    ising_run_ctrl #(
        .N(N),
        .DEPTH(DEPTH),
        .RST_CYCLES(RSTC),
        .CNT_W(CNT_W)
`ifdef ISING_EARLY_STOP_EN
        ,
        .STABLE_CYCLES(8)
`endif
    ) dut (
        .clk(clk),
        .ising_rst(ising_rst),
        .start(start),
        .abort(abort),
        .num_runs(num_runs),
        .run_cycles(run_cycles),
        .phase_in(phase_in),
        .core_rstn(core_rstn),
        .busy(busy),
        .done(done),
        .overflow(overflow),
        .run_count(run_count),
`ifdef ISING_EARLY_STOP_EN
        .early_stops(early_stops),
`endif
        .rd_addr(rd_addr),
        .rd_data(rd_data)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic readBack();
        for (int k = 0; k < DEPTH; k++) begin
            if (model_valid[k]) begin
                rd_addr = AW'(k);
                @(posedge clk); #1;
                checkOutput($sformatf("rd_data[%0d]", k), 32'(rd_data), 32'(model_buf[k]));
            end
        end
    endtask

    // One batch: the expected core_rstn schedule is built up front from run lengths,
    // then random phase/start/parameter noise is applied every cycle while it is checked.
    task automatic applyStimulus(input int nr, input int rc, input int abort_at);
        bit exp_rstn[$];
        bit exp_capt[$];
        int eff;
        int caps;
        int len;
        eff = (rc == 0) ? 1 : rc;
        for (int r = 0; r < nr; r++) begin
            for (int c = 0; c < RSTC; c++) begin
                exp_rstn.push_back(1'b0);
                exp_capt.push_back(1'b0);
            end
            for (int h = 0; h <= eff; h++) begin
                exp_rstn.push_back(1'b1);
                exp_capt.push_back(h == eff);
            end
        end
        exp_rstn.push_back(1'b0);
        exp_capt.push_back(1'b0);
        len = exp_rstn.size();

        num_runs   = 16'(nr);
        run_cycles = CNT_W'(rc);
        phase_in   = N'($urandom);
        start      = 1'b1;
        @(posedge clk); #1;
        caps = 0;
        for (int j = 0; j < len; j++) begin
            if (j == abort_at) begin
                start = 1'b0;
                abort = 1'b1;
                @(posedge clk); #1;
                abort = 1'b0;
                checkOutput("abort_busy", 32'(busy), 32'd0);
                checkOutput("abort_rstn", 32'(core_rstn), 32'd0);
                checkOutput("abort_done", 32'(done), 32'd0);
                checkOutput("abort_count", 32'(run_count), 32'(caps));
                @(posedge clk); #1;
                checkOutput("abort_nodone", 32'(done), 32'd0);
                return;
            end
            checkOutput($sformatf("rstn[%0d]", j), 32'(core_rstn), 32'(exp_rstn[j]));
            checkOutput($sformatf("busy[%0d]", j), 32'(busy), 32'd1);
            checkOutput($sformatf("done[%0d]", j), 32'(done), 32'(j == len - 1));
            phase_in   = N'($urandom);
            start      = 1'($urandom_range(0, 1));
            num_runs   = 16'($urandom);
            run_cycles = CNT_W'($urandom);
            if (exp_capt[j]) begin
                model_buf[caps % DEPTH]   = phase_in;
                model_valid[caps % DEPTH] = 1'b1;
                caps++;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        checkOutput("end_busy", 32'(busy), 32'd0);
        checkOutput("end_done", 32'(done), 32'd0);
        checkOutput("end_rstn", 32'(core_rstn), 32'd0);
        checkOutput("run_count", 32'(run_count), 32'(caps));
        checkOutput("overflow", 32'(overflow), 32'(caps > DEPTH));
        readBack();
    endtask

    initial begin
        ising_rst  = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        num_runs   = 16'd0;
        run_cycles = '0;
        phase_in   = '0;
        rd_addr    = '0;
        #12;
        checkOutput("rst_rstn", 32'(core_rstn), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_ovf", 32'(overflow), 32'd0);
        checkOutput("rst_count", 32'(run_count), 32'd0);
        checkOutput("rst_rd_data", 32'(rd_data), 32'd0);
        @(negedge clk);
        ising_rst = 1'b0;
        @(posedge clk); #1;

        applyStimulus(3, 10, -1);

        // start and abort together in IDLE must not begin a batch
        num_runs = 16'd5;
        run_cycles = CNT_W'(3);
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        checkOutput("collide_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        checkOutput("collide_busy2", 32'(busy), 32'd0);

        applyStimulus(0, 5, -1);
        applyStimulus(2, 0, -1);
        applyStimulus(18, 2, -1);
        applyStimulus(3, 10, 23);

        // asynchronous reset during the second run's RSTQ
        phase_in   = N'(3);
        num_runs   = 16'd2;
        run_cycles = CNT_W'(5);
        start      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (11) @(posedge clk);
        model_buf[0]   = N'(3);
        model_valid[0] = 1'b1;
        #3;
        ising_rst = 1'b1;
        #1;
        checkOutput("mid_rst_rstn", 32'(core_rstn), 32'd0);
        checkOutput("mid_rst_busy", 32'(busy), 32'd0);
        checkOutput("mid_rst_count", 32'(run_count), 32'd0);
        checkOutput("mid_rst_ovf", 32'(overflow), 32'd0);
        checkOutput("mid_rst_rd_data", 32'(rd_data), 32'd0);
        @(negedge clk);
        ising_rst = 1'b0;
        @(posedge clk); #1;
        checkOutput("post_rst_done", 32'(done), 32'd0);

        applyStimulus(4, 6, -1);
        for (int b = 0; b < 8; b++)
            applyStimulus(int'($urandom_range(0, 20)), int'($urandom_range(0, 12)), -1);

`ifdef ISING_EARLY_STOP_EN
        begin
            int hi;
            num_runs   = 16'd1;
            run_cycles = CNT_W'(100);
            phase_in   = '0;
            start      = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            for (int c = 0; c < RSTC; c++) begin
                checkOutput("es_rstq", 32'(core_rstn), 32'd0);
                @(posedge clk); #1;
            end
            hi = 0;
            while (core_rstn && hi < 200) begin
                hi++;
                phase_in = (hi == 1) ? N'(1) : (hi == 2) ? N'(2) : N'(5);
                @(posedge clk); #1;
            end
            // constant from RUN cycle 3: eight stable cycles end RUN at cycle 11, then CAPT
            checkOutput("es_high_cycles", 32'(hi), 32'd12);
            checkOutput("es_done", 32'(done), 32'd1);
            checkOutput("es_count", 32'(early_stops), 32'd1);
            model_buf[0]   = N'(5);
            model_valid[0] = 1'b1;
            @(posedge clk); #1;
            readBack();
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
